md_sequencer: RTL
=================

// Module: md_sequencer
// PURPOSE
//  Iterative signed MULT/DIV engine plus the FSM that sequences it. Sits beside the
//  register file on A/B outputs and feeds the HI/LO registers. Main control FSM
//  issues one start pulse, waits for done, then reads hi_out/lo_out and the
//  div_by_zero flag. One op in flight; radix-2, one iteration per clock.
// PARAMETERS
//  WIDTH  32  operand width; even, >=4. HI/LO are WIDTH each. CNT_W=$clog2(WIDTH)+1 is a localparam.
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-high; one clock, one reset for whole block
//  start        in   1      request; sampled only in IDLE
//  op           in   2      00=MULT, 01=DIV, 1x=reserved (start ignored)
//  a_in         in   WIDTH  multiplicand / dividend (signed), sampled with start
//  b_in         in   WIDTH  multiplier / divisor (signed), sampled with start
//  busy         out  1      high in RUN, FIXUP, DONE
//  done         out  1      one-cycle pulse in DONE
//  hi_we        out  1      =done & ~div_by_zero
//  lo_we        out  1      =done & ~div_by_zero
//  div_by_zero  out  1      one-cycle pulse with done when DIV and b_in==0
//  hi_out       out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo_out       out  WIDTH  MULT: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all outputs 0, hi_out/lo_out=0; reset overrides start.
//  States: IDLE, RUN, FIXUP, DONE.
//   IDLE : start & op==00 -> RUN; start & op==01 & b_in!=0 -> RUN;
//          start & op==01 & b_in==0 -> DONE with dbz flag set; else stay.
//          On accept: latch |a|,|b|, sign_a, sign_b, op; counter<=0.
//   RUN  : one shift-add (MULT) / restoring subtract-shift (DIV) step per clock;
//          counter++; after WIDTH steps (counter==WIDTH-1 on exit) -> FIXUP.
//   FIXUP: apply signs; register hi_out/lo_out -> DONE.
//   DONE : done=1, hi_we/lo_we or div_by_zero as above -> IDLE.
//  Latency: start accepted in cycle t -> done in cycle t+WIDTH+2 (t+34 at 32);
//   div-by-zero -> done in cycle t+1. Next start accepted in cycle after DONE.
//  Arithmetic: MULT full 2W-bit signed product, never overflows.
//   DIV truncates toward zero; remainder has sign of dividend (0 if rem==0).
//   -2^(W-1) / -1: quotient wraps to 0x80000000, remainder 0, no flag.
//   Magnitudes held in W+1 bits so |-2^(W-1)| is exact.
//  Boundaries: start while busy ignored, operands not re-sampled; op 1x ignored.
//   hi_out/lo_out hold last result until next FIXUP; div-by-zero leaves them unchanged.
//   Reset mid-RUN -> IDLE next clock, no done, no hi_we/lo_we, outputs zeroed.
//   a_in/b_in may change freely after accept cycle.
// STRUCTURE
//  Shared include md_defs.vh: op codes (MD_MULT, MD_DIV), state encodings, WIDTH default.
//  One sub-module: md_step -- combinational single radix-2 iteration (add/shift for
//  MULT, trial-subtract/shift for DIV); md_sequencer owns FSM, counter, registers, sign fix.
// TESTING
//  MULT 7 x 0xFFFFFFFD at t -> done t+34, hi_we=lo_we=1, HI=FFFFFFFF LO=FFFFFFEB.
//  MULT 80000000 x 80000000 -> HI=40000000 LO=00000000.
//  DIV 0xFFFFFFF9 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV 7/0xFFFFFFFE -> LO=FFFFFFFD HI=1.
//  DIV 5 / 0 at t -> done & div_by_zero at t+1, hi_we=lo_we=0, HI/LO unchanged.
//  DIV 80000000 / FFFFFFFF -> LO=80000000, HI=00000000, div_by_zero=0.
//  Start MULT, pulse start with new operands at t+5, reset at t+10 -> busy=0 at t+11,
//   no done pulse; fresh MULT 3x4 then yields LO=0000000C HI=0.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the MULT/DIV sequencer: op codes, FSM states, default width.
package md_sequencer_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [1:0] OpMult = 2'b00;
  localparam logic [1:0] OpDiv  = 2'b01;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFixup = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Codes with the top bit set are reserved; a start carrying one is dropped.
  function automatic logic op_valid(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Request/result bundle between the control FSM (master) and the MULT/DIV engine (slave).
interface md_sequencer_if
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             hi_we;
  logic             lo_we;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, hi_we, lo_we, div_by_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, hi_we, lo_we, div_by_zero, hi_out, lo_out
  );

endinterface

// File: rtl/md_sequencer_step.sv
// One radix-2 iteration on unsigned magnitudes.
// MULT: {hi,lo} holds partial product / remaining multiplier bits; m is the multiplicand.
// DIV : hi holds the partial remainder, lo the dividend bits shifting out and quotient
//       bits shifting in; m is the divisor.
module md_sequencer_step
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;

  // Add-then-shift-right for MULT, shift-left-then-trial-subtract for DIV.
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    // Partial remainder is always below the divisor, so hi[WIDTH] is zero here.
    trial  = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff   = {1'b0, trial} - {1'b0, m};
    hi_nxt = sum[WIDTH+1:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        hi_nxt = diff[WIDTH:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = trial;
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Iterative signed MULT/DIV engine with its sequencing FSM: IDLE -> RUN (WIDTH steps)
// -> FIXUP (apply signs, register result) -> DONE (one-cycle pulse) -> IDLE.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic          clock,
  input  logic          reset,
  md_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     m_q, m_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_out_q, hi_out_d;
  logic [WIDTH-1:0]   lo_out_q, lo_out_d;

  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;

  // Magnitudes carry one extra bit so that |-2^(WIDTH-1)| is representable.
  always_comb begin
    a_ext = {bus.a_in[WIDTH-1], bus.a_in};
    b_ext = {bus.b_in[WIDTH-1], bus.b_in};
    a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
  end

  md_sequencer_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div (is_div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .m      (m_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Sign fix-up of the raw magnitude results; remainder follows the dividend's sign.
  always_comb begin
    prod_mag    = {hi_q[WIDTH-1:0], lo_q};
    prod_signed = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    quo_signed  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_signed  = sign_a_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
  end

  // Next-state logic: accept in IDLE, iterate in RUN, register result in FIXUP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    hi_out_d = hi_out_q;
    lo_out_d = lo_out_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && op_valid(bus.op)) begin
          sign_a_d = bus.a_in[WIDTH-1];
          sign_b_d = bus.b_in[WIDTH-1];
          is_div_d = (bus.op == OpDiv);
          cnt_d    = '0;
          hi_d     = '0;
          if (bus.op == OpDiv) begin
            lo_d = a_mag[WIDTH-1:0];
            m_d  = b_mag;
          end else begin
            lo_d = b_mag[WIDTH-1:0];
            m_d  = a_mag;
          end
          if ((bus.op == OpDiv) && (bus.b_in == '0)) begin
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            dbz_d   = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        if (is_div_q) begin
          hi_out_d = rem_signed;
          lo_out_d = quo_signed;
        end else begin
          hi_out_d = prod_signed[2*WIDTH-1:WIDTH];
          lo_out_d = prod_signed[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      hi_out_q <= '0;
      lo_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
      hi_out_q <= hi_out_d;
      lo_out_q <= lo_out_d;
    end
  end

  // Status and write-enable outputs decoded from state.
  always_comb begin
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
    bus.hi_we       = bus.done & ~dbz_q;
    bus.lo_we       = bus.done & ~dbz_q;
    bus.div_by_zero = bus.done & dbz_q;
    bus.hi_out      = hi_out_q;
    bus.lo_out      = lo_out_q;
  end

endmodule
